mult_result_sink: RTL and testbench

Downstream companion to the 8x8 shift-add multiplier. It shares the multiplier's clock and reset and tracks the multiplier's fixed 10-cycle frame with its own phase counter. It samples the operands the multiplier loads at phase 0 and captures the finished 16-bit product at phase 9. Each tagged result is buffered in a small FIFO and presented to the consumer on a valid/ready interface.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_result_sink_fifo.sv | 69 ++++++
 rtl/mult_result_sink.sv | 97 +++++++++
 tb/tb_mult_result_sink.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared frame constants and result-entry type for the shift-add multiplier
// and its downstream result sink.
package mult_pkg;

    localparam int FRAME_LEN  = 10;
    localparam int LOAD_PHASE = 0;
    localparam int PROD_PHASE = 9;
    localparam int PHASE_W    = 4;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } mult_entry_t;

endpackage

// File: rtl/mult_result_sink_fifo.sv
// Synchronous FIFO with a registered head, occupancy-based full/empty and
// push-while-full acceptance when a pop happens in the same cycle.
module sync_fifo
    import mult_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = mult_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en_i,
    input  T     wr_data_i,
    input  logic rd_en_i,
    output logic full_o,
    output logic valid_o,
    output T     head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    T              head_q, head_d;
    T              mem_q [DEPTH];
    logic          push, pop;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign valid_o = (count_q != '0);
    assign head_o  = head_q;

    assign pop  = rd_en_i && valid_o;
    assign push = wr_en_i && (!full_o || pop);

    // The head is kept in its own register so it resets to zero and holds the
    // last value once the FIFO drains.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + (AW + 1)'(1);
        if (pop && !push) count_d = count_q - (AW + 1)'(1);
        head_d   = head_q;
        if (count_d != '0) begin
            if (push && wr_ptr_q == rd_ptr_d) head_d = wr_data_i;
            else                              head_d = mem_q[rd_ptr_d];
        end
    end

    // NOTE: storage carries no reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/mult_result_sink.sv
// Tracks the multiplier's 10-cycle frame, tags each finished product with its
// operands and queues it for a valid/ready consumer. MULT_SINK_CHECK_EN adds a product checker.
module mult_result_sink
    import mult_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in1,
    input  logic [7:0]        in2,
    input  logic              op_valid,
    input  logic [15:0]       prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_a,
    output logic [7:0]        out_b,
    output logic [15:0]       out_prod,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              err
);

    logic [PHASE_W-1:0] phase_q;
    logic [7:0]         a_q, b_q;
    logic               pending_q;
    logic [DROP_W-1:0]  drop_q;

    logic        push, full, drop;
    mult_entry_t entry, head;

    assign push = (phase_q == PHASE_W'(PROD_PHASE)) && pending_q;
    // A full FIFO still accepts the push when the consumer pops in the same cycle.
    assign drop = push && full && !(out_valid && out_ready);

    assign entry.a    = a_q;
    assign entry.b    = b_q;
    assign entry.prod = prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            pending_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            phase_q <= (phase_q == PHASE_W'(FRAME_LEN - 1)) ? '0 : phase_q + PHASE_W'(1);
            if (phase_q == PHASE_W'(LOAD_PHASE)) begin
                pending_q <= op_valid;
                if (op_valid) begin
                    a_q <= in1;
                    b_q <= in2;
                end
            end else if (push) begin
                pending_q <= 1'b0;
            end
            if (drop && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (mult_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (entry),
        .rd_en_i   (out_ready),
        .full_o    (full),
        .valid_o   (out_valid),
        .head_o    (head)
    );

    assign out_a    = head.a;
    assign out_b    = head.b;
    assign out_prod = head.prod;
    assign drop_cnt = drop_q;

`ifdef MULT_SINK_CHECK_EN
    logic        err_q;
    logic [15:0] expect_prod;

    assign expect_prod = 16'(a_q) * 16'(b_q);

    always_ff @(posedge clk) begin
        if (rst)                               err_q <= 1'b0;
        else if (push && prod != expect_prod)  err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_result_sink.sv
// Randomized and directed bench for mult_result_sink against a frame-level
// queue model; the multiplier is modelled as an ideal product source at phase 9.
module tb_mult_result_sink;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in1 = '0, in2 = '0;
    logic        op_valid = 1'b0;
    logic [15:0] prod = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [7:0]  out_a, out_b;
    logic [15:0] out_prod;
    logic [7:0]  drop_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_phase = 0;
    bit          m_pending = 0;
    logic [7:0]  m_a = '0, m_b = '0, mul_a = '0, mul_b = '0;
    logic [31:0] q[$];
    logic [31:0] m_head = '0;
    int          m_drop = 0;
    bit          m_err = 0;
    bit          force_zero = 0;

    mult_result_sink #(.DEPTH(DEPTH), .DROP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .op_valid  (op_valid),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_prod  (out_prod),
        .drop_cnt  (drop_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the model, then land 1 time unit after the edge.
    task automatic tick(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit rdy, input bit r);
        bit pop, push, accept;
        int sz;
        logic [31:0] ent;
        rst = r;
        out_ready = rdy;
        if (m_phase == 0) begin
            in1 = a; in2 = b; op_valid = v;
        end else begin
            in1 = 8'($urandom); in2 = 8'($urandom); op_valid = 1'($urandom);
        end
        if (m_phase == 9) prod = force_zero ? 16'd0 : 16'(mul_a) * 16'(mul_b);
        else              prod = 16'($urandom);

        if (r) begin
            q.delete();
            m_pending = 0; m_drop = 0; m_err = 0; m_phase = 0; m_head = '0;
        end else begin
            sz   = q.size();
            pop  = (sz != 0) && rdy;
            push = (m_phase == 9) && m_pending;
            if (m_phase == 0) begin
                mul_a = in1; mul_b = in2;
                m_pending = v;
                if (v) begin m_a = a; m_b = b; end
            end
            if (push) begin
                ent = {m_a, m_b, prod};
                m_pending = 0;
`ifdef MULT_SINK_CHECK_EN
                if (prod != 16'(m_a) * 16'(m_b)) m_err = 1;
`endif
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                accept = (sz < DEPTH) || pop;
                if (accept) q.push_back(ent);
                else if (m_drop < 255) m_drop++;
            end
            if (q.size() != 0) m_head = q[0];
            m_phase = (m_phase == 9) ? 0 : m_phase + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input bit v, input logic [7:0] a, input logic [7:0] b, input bit rdy);
        repeat (10) tick(v, a, b, rdy, 0);
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
        checks++;
        if ({out_a, out_b, out_prod} !== 32'd0) begin
            errors++; $display("FAIL reset_head got %h exp 0", {out_a, out_b, out_prod});
        end
        checks++;
        if (drop_cnt !== 8'd0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_cnt got drop=%0d err=%0d exp 0 0", drop_cnt, err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        frame(1, 8'd13, 8'd11, 1);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 8'd13 || out_b !== 8'd11 || out_prod !== 16'd143) begin
            errors++;
            $display("FAIL basic got v=%0d a=%0d b=%0d p=%0d exp 1 13 11 143", out_valid, out_a, out_b, out_prod);
        end
        tick(0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %0d exp 0", out_valid); end
        repeat (9) tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_extreme();
        do_reset();
        frame(1, 8'd255, 8'd255, 1);
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 16'd65025) begin
            errors++; $display("FAIL extreme_max got v=%0d p=%0d exp 1 65025", out_valid, out_prod);
        end
        frame(1, 8'd0, 8'd200, 1);
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 16'd0 || out_b !== 8'd200) begin
            errors++; $display("FAIL extreme_zero got v=%0d b=%0d p=%0d exp 1 200 0", out_valid, out_b, out_prod);
        end
    endtask

    task automatic test_idle();
        do_reset();
        frame(0, 8'd9, 8'd9, 1);
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL idle got v=%0d drop=%0d exp 0 0", out_valid, drop_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ops_a [6] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd1, 8'd2};
        logic [7:0] ops_b [6] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd5, 8'd3};
        do_reset();
        for (int i = 0; i < 6; i++) frame(1, ops_a[i], ops_b[i], 0);
        checks++;
        if (drop_cnt !== 8'd2) begin errors++; $display("FAIL overflow_drop got %0d exp 2", drop_cnt); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_prod !== 16'(i)) begin
                errors++; $display("FAIL overflow_drain%0d got v=%0d p=%0d exp 1 %0d", i, out_valid, out_prod, i);
            end
            tick(0, 0, 0, 1, 0);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL overflow_empty got %0d exp 0", out_valid); end
        repeat (6) tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame(1, 8'd1, 8'd2, 0);
        frame(1, 8'd3, 8'd4, 0);
        repeat (5) tick(1, 8'd7, 8'd7, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 16'd2) begin
            errors++; $display("FAIL midrst_pre got v=%0d p=%0d exp 1 2", out_valid, out_prod);
        end
        tick(0, 0, 0, 0, 1);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL midrst_clear got v=%0d drop=%0d exp 0 0", out_valid, drop_cnt);
        end
        frame(0, 8'd7, 8'd7, 0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_nopush got %0d exp 0", out_valid); end
        frame(1, 8'd7, 8'd9, 1);
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 16'd63) begin
            errors++; $display("FAIL midrst_realign got v=%0d p=%0d exp 1 63", out_valid, out_prod);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 262; i++) frame(1, 8'($urandom), 8'($urandom), 0);
        checks++;
        if (drop_cnt !== 8'(m_drop) || m_drop != 255) begin
            errors++; $display("FAIL saturate got %0d exp 255", drop_cnt);
        end
    endtask

    task automatic test_checker();
        bit exp_err;
`ifdef MULT_SINK_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        do_reset();
        force_zero = 1;
        frame(1, 8'd3, 8'd5, 0);
        force_zero = 0;
        checks++;
        if (out_valid !== 1'b1 || {out_a, out_b, out_prod} !== {8'd3, 8'd5, 16'd0}) begin
            errors++; $display("FAIL checker_entry got v=%0d %0d %0d %0d exp 1 3 5 0", out_valid, out_a, out_b, out_prod);
        end
        frame(1, 8'd2, 8'd2, 1);
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL checker_err got %0d exp %0d", err, exp_err); end
    endtask

    task automatic test_random();
        bit v, rdy;
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = (c < 600) ? ($urandom_range(0, 7) == 0) : 1'($urandom);
            force_zero = ($urandom_range(0, 15) == 0);
            tick(v, 8'($urandom), 8'($urandom), rdy, 0);
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_valid c=%0d got %0d exp %0d", c, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({out_a, out_b, out_prod} !== m_head) begin
                    errors++; $display("FAIL rand_head c=%0d got %h exp %h", c, {out_a, out_b, out_prod}, m_head);
                end
            end
            checks++;
            if (drop_cnt !== 8'(m_drop) || err !== m_err) begin
                errors++; $display("FAIL rand_status c=%0d got drop=%0d err=%0d exp %0d %0d", c, drop_cnt, err, m_drop, m_err);
            end
        end
        force_zero = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_idle();
        test_overflow();
        test_reset_mid();
        test_checker();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
